// File: rtl/pfcoreif_pkg.sv
// Shared payload types, default queue depths and helpers for the core <-> prefetch-monitor bridge.
package pfcoreif_pkg;

    localparam int DEC_DEPTH_D  = 4;
    localparam int RET_DEPTH_D  = 8;
    localparam int PRED_DEPTH_D = 2;
    localparam int CNT_W        = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  tag;
    } I_core_pfdecode_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  tag;
    } I_core_pfretire_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  conf;
    } I_pftocore_pred_type;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pfcoreif_if.sv
// Valid/retry channels between core, bridge and prefetch monitor; slave is the bridge side.
interface pfcoreif_if;
    import pfcoreif_pkg::*;

    logic                coredec_valid;
    I_core_pfdecode_type coredec;
    logic                coreret_valid;
    I_core_pfretire_type coreret;

    I_core_pfdecode_type pfdecode;
    logic                pfdecode_valid;
    logic                pfdecode_retry;
    I_core_pfretire_type pfretire;
    logic                pfretire_valid;
    logic                pfretire_retry;

    I_pftocore_pred_type pfpred;
    logic                pfpred_valid;
    logic                pfpred_retry;
    I_pftocore_pred_type corepred;
    logic                corepred_valid;
    logic                corepred_retry;

    modport slave (
        input  coredec_valid, coredec, coreret_valid, coreret,
        output pfdecode, pfdecode_valid, input pfdecode_retry,
        output pfretire, pfretire_valid, input pfretire_retry,
        input  pfpred, pfpred_valid, output pfpred_retry,
        output corepred, corepred_valid, input corepred_retry
    );

    modport master (
        output coredec_valid, coredec, coreret_valid, coreret,
        input  pfdecode, pfdecode_valid, output pfdecode_retry,
        input  pfretire, pfretire_valid, output pfretire_retry,
        output pfpred, pfpred_valid, input pfpred_retry,
        input  corepred, corepred_valid, output corepred_retry
    );

endinterface

// File: rtl/pfcoreif_fifo.sv
// Order-preserving FIFO with wrap-bit pointers; caller guarantees no push when full without a pop.
module pfcoreif_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Payload storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

endmodule

// File: rtl/pfcoreif.sv
// Bridge queuing core decode/retire events to the prefetch monitor and predictions back to the core.
module pfcoreif
    import pfcoreif_pkg::*;
#(
    parameter int DEC_DEPTH  = DEC_DEPTH_D,
    parameter int RET_DEPTH  = RET_DEPTH_D,
    parameter int PRED_DEPTH = PRED_DEPTH_D
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_pf_enable,
    pfcoreif_if.slave        io_pf,
    output logic [CNT_W-1:0] o_dec_drop_cnt,
    output logic [CNT_W-1:0] o_ret_drop_cnt
);

    logic w_dec_full, w_dec_empty, w_dec_push, w_dec_pop, w_dec_drop;
    logic w_ret_full, w_ret_empty, w_ret_push, w_ret_pop, w_ret_drop;
    logic w_pred_full, w_pred_empty, w_pred_push, w_pred_pop;

    logic [CNT_W-1:0] r_dec_drop_cnt;
    logic [CNT_W-1:0] r_ret_drop_cnt;

    // Valids are masked during reset so nothing transfers before the pointers clear.
    assign io_pf.pfdecode_valid = ~w_dec_empty & ~reset;
    assign io_pf.pfretire_valid = ~w_ret_empty & ~reset;
    assign io_pf.corepred_valid = ~w_pred_empty & ~reset;

    assign w_dec_pop  = io_pf.pfdecode_valid & ~io_pf.pfdecode_retry;
    assign w_ret_pop  = io_pf.pfretire_valid & ~io_pf.pfretire_retry;
    assign w_pred_pop = io_pf.corepred_valid & ~io_pf.corepred_retry;

    assign w_dec_push = i_pf_enable & io_pf.coredec_valid & (~w_dec_full | w_dec_pop);
    assign w_dec_drop = i_pf_enable & io_pf.coredec_valid & w_dec_full & ~w_dec_pop;
    assign w_ret_push = i_pf_enable & io_pf.coreret_valid & (~w_ret_full | w_ret_pop);
    assign w_ret_drop = i_pf_enable & io_pf.coreret_valid & w_ret_full & ~w_ret_pop;

    // While disabled, predictions are accepted and thrown away rather than back-pressured.
    assign io_pf.pfpred_retry = i_pf_enable & w_pred_full & ~w_pred_pop & ~reset;
    assign w_pred_push        = i_pf_enable & io_pf.pfpred_valid & ~io_pf.pfpred_retry & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_drop_cnt <= '0;
            r_ret_drop_cnt <= '0;
        end else begin
            if (w_dec_drop) r_dec_drop_cnt <= sat_inc(r_dec_drop_cnt);
            if (w_ret_drop) r_ret_drop_cnt <= sat_inc(r_ret_drop_cnt);
        end
    end

    assign o_dec_drop_cnt = r_dec_drop_cnt;
    assign o_ret_drop_cnt = r_ret_drop_cnt;

    pfcoreif_fifo #(.DEPTH(DEC_DEPTH), .T(I_core_pfdecode_type)) u_dec_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_dec_push),
        .i_data  (io_pf.coredec),
        .i_pop   (w_dec_pop),
        .o_data  (io_pf.pfdecode),
        .o_full  (w_dec_full),
        .o_empty (w_dec_empty)
    );

    pfcoreif_fifo #(.DEPTH(RET_DEPTH), .T(I_core_pfretire_type)) u_ret_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_ret_push),
        .i_data  (io_pf.coreret),
        .i_pop   (w_ret_pop),
        .o_data  (io_pf.pfretire),
        .o_full  (w_ret_full),
        .o_empty (w_ret_empty)
    );

    pfcoreif_fifo #(.DEPTH(PRED_DEPTH), .T(I_pftocore_pred_type)) u_pred_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_pred_push),
        .i_data  (io_pf.pfpred),
        .i_pop   (w_pred_pop),
        .o_data  (io_pf.corepred),
        .o_full  (w_pred_full),
        .o_empty (w_pred_empty)
    );

endmodule

// File: tb/tb_pfcoreif.sv
// Scoreboard bench for pfcoreif: directed stimulus pushes expected transfers, a monitor compares them.
module tb_pfcoreif;
    import pfcoreif_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pf_enable;
    logic [15:0] dec_drop_cnt;
    logic [15:0] ret_drop_cnt;

    pfcoreif_if u_if ();

    pfcoreif u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_pf_enable    (pf_enable),
        .io_pf          (u_if),
        .o_dec_drop_cnt (dec_drop_cnt),
        .o_ret_drop_cnt (ret_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int dec_xfers = 0;

    I_core_pfdecode_type exp_dec[$];
    I_core_pfretire_type exp_ret[$];
    I_pftocore_pred_type exp_pred[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic I_core_pfdecode_type mk_dec(input int i);
        I_core_pfdecode_type d;
        d.pc  = 32'h1000_0000 + 32'(i) * 32'd4;
        d.tag = 4'(i);
        return d;
    endfunction

    function automatic I_core_pfretire_type mk_ret(input int i);
        I_core_pfretire_type r;
        r.pc  = 32'h2000_0000 + 32'(i) * 32'd4;
        r.tag = 4'(i);
        return r;
    endfunction

    function automatic I_pftocore_pred_type mk_pred(input int i);
        I_pftocore_pred_type p;
        p.addr = 32'h3000_0000 + 32'(i) * 32'd64;
        p.conf = 2'(i);
        return p;
    endfunction

    task automatic drain(input int max_cyc);
        int c = 0;
        while ((exp_dec.size() + exp_ret.size() + exp_pred.size()) != 0 && c < max_cyc) begin
            tick();
            c++;
        end
        check("drain_pending", 64'(exp_dec.size() + exp_ret.size() + exp_pred.size()), 64'd0);
    endtask

    initial begin
        int x0;
        reset = 1'b1;
        pf_enable = 1'b1;
        u_if.coredec_valid = 1'b0;  u_if.coredec = '0;
        u_if.coreret_valid = 1'b0;  u_if.coreret = '0;
        u_if.pfdecode_retry = 1'b0; u_if.pfretire_retry = 1'b0;
        u_if.pfpred_valid = 1'b0;   u_if.pfpred = '0;
        u_if.corepred_retry = 1'b0;

        fork
            forever begin
                I_core_pfdecode_type ed;
                I_core_pfretire_type er;
                I_pftocore_pred_type ep;
                @(negedge clk);
                if (!reset) begin
                    if (u_if.pfdecode_valid && !u_if.pfdecode_retry) begin
                        dec_xfers++;
                        if (exp_dec.size() == 0) check("dec_unexpected", 64'(u_if.pfdecode), 64'd0 - 64'd1);
                        else begin ed = exp_dec.pop_front(); check("dec_payload", 64'(u_if.pfdecode), 64'(ed)); end
                    end
                    if (u_if.pfretire_valid && !u_if.pfretire_retry) begin
                        if (exp_ret.size() == 0) check("ret_unexpected", 64'(u_if.pfretire), 64'd0 - 64'd1);
                        else begin er = exp_ret.pop_front(); check("ret_payload", 64'(u_if.pfretire), 64'(er)); end
                    end
                    if (u_if.corepred_valid && !u_if.corepred_retry) begin
                        if (exp_pred.size() == 0) check("pred_unexpected", 64'(u_if.corepred), 64'd0 - 64'd1);
                        else begin ep = exp_pred.pop_front(); check("pred_payload", 64'(u_if.corepred), 64'(ep)); end
                    end
                end
            end
        join_none

        tick(); tick();
        check("rst_dec_valid", 64'(u_if.pfdecode_valid), 64'd0);
        check("rst_ret_valid", 64'(u_if.pfretire_valid), 64'd0);
        check("rst_pred_valid", 64'(u_if.corepred_valid), 64'd0);
        check("rst_pfpred_retry", 64'(u_if.pfpred_retry), 64'd0);
        check("rst_dec_drop", 64'(dec_drop_cnt), 64'd0);
        check("rst_ret_drop", 64'(ret_drop_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // Single decode: no bypass, visible next cycle, empties after transfer.
        u_if.coredec_valid = 1'b1; u_if.coredec = mk_dec(1); exp_dec.push_back(mk_dec(1));
        check("dec_no_bypass", 64'(u_if.pfdecode_valid), 64'd0);
        tick();
        u_if.coredec_valid = 1'b0;
        check("dec_valid_next", 64'(u_if.pfdecode_valid), 64'd1);
        tick();
        check("dec_empty_after", 64'(u_if.pfdecode_valid), 64'd0);

        // Retire overflow: 10 events into 8 entries while held.
        u_if.pfretire_retry = 1'b1;
        for (int i = 0; i < 10; i++) begin
            u_if.coreret_valid = 1'b1; u_if.coreret = mk_ret(i);
            if (i < 8) exp_ret.push_back(mk_ret(i));
            tick();
        end
        u_if.coreret_valid = 1'b0;
        check("ret_drop_2", 64'(ret_drop_cnt), 64'd2);
        u_if.pfretire_retry = 1'b0;
        drain(20);
        check("ret_drop_hold", 64'(ret_drop_cnt), 64'd2);

        // Decode full with simultaneous pop: accepted, no drop, still full.
        u_if.pfdecode_retry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.coredec_valid = 1'b1; u_if.coredec = mk_dec(10 + i); exp_dec.push_back(mk_dec(10 + i));
            tick();
        end
        u_if.pfdecode_retry = 1'b0;
        u_if.coredec = mk_dec(14); exp_dec.push_back(mk_dec(14));
        tick();
        check("dec_full_pop_nodrop", 64'(dec_drop_cnt), 64'd0);
        u_if.pfdecode_retry = 1'b1;
        u_if.coredec = mk_dec(15);
        tick();
        u_if.coredec_valid = 1'b0;
        check("dec_still_full_drop", 64'(dec_drop_cnt), 64'd1);
        u_if.pfdecode_retry = 1'b0;
        drain(20);

        // Prediction back-pressure with depth 2.
        u_if.corepred_retry = 1'b1;
        u_if.pfpred_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            u_if.pfpred = mk_pred(i); exp_pred.push_back(mk_pred(i));
            check("pred_retry_low", 64'(u_if.pfpred_retry), 64'd0);
            tick();
        end
        u_if.pfpred = mk_pred(2); exp_pred.push_back(mk_pred(2));
        check("pred_retry_full", 64'(u_if.pfpred_retry), 64'd1);
        tick();
        check("pred_retry_held", 64'(u_if.pfpred_retry), 64'd1);
        u_if.corepred_retry = 1'b0;
        #1;
        check("pred_retry_release", 64'(u_if.pfpred_retry), 64'd0);
        tick();
        u_if.pfpred_valid = 1'b0;
        drain(20);

        // Disable with queued decodes: only the queued ones drain.
        u_if.pfdecode_retry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.coredec_valid = 1'b1; u_if.coredec = mk_dec(20 + i); exp_dec.push_back(mk_dec(20 + i));
            tick();
        end
        pf_enable = 1'b0;
        u_if.pfdecode_retry = 1'b0;
        u_if.corepred_retry = 1'b1;
        u_if.pfpred_valid = 1'b1; u_if.pfpred = mk_pred(9);
        x0 = dec_xfers;
        for (int i = 0; i < 5; i++) begin
            u_if.coredec = mk_dec(30 + i);
            tick();
        end
        u_if.coredec_valid = 1'b0;
        check("dis_pfpred_retry", 64'(u_if.pfpred_retry), 64'd0);
        u_if.pfpred_valid = 1'b0;
        tick(); tick(); tick();
        check("dis_xfers_3", 64'(dec_xfers - x0), 64'd3);
        check("dis_drop_same", 64'(dec_drop_cnt), 64'd1);
        check("dis_pred_discard", 64'(u_if.corepred_valid), 64'd0);
        pf_enable = 1'b1;
        u_if.corepred_retry = 1'b0;
        drain(5);

        // Saturation, then reset with entries queued everywhere.
        u_if.pfdecode_retry = 1'b1; u_if.pfretire_retry = 1'b1; u_if.corepred_retry = 1'b1;
        u_if.coreret_valid = 1'b1; u_if.coreret = mk_ret(5); exp_ret.push_back(mk_ret(5));
        u_if.pfpred_valid = 1'b1;  u_if.pfpred = mk_pred(5); exp_pred.push_back(mk_pred(5));
        u_if.coredec_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.coredec = mk_dec(40 + i); exp_dec.push_back(mk_dec(40 + i));
            tick();
            u_if.coreret_valid = 1'b0; u_if.pfpred_valid = 1'b0;
        end
        u_if.coredec = mk_dec(50);
        repeat (65540) tick();
        u_if.coredec_valid = 1'b0;
        check("dec_drop_sat", 64'(dec_drop_cnt), 64'hFFFF);
        check("pre_rst_dec_valid", 64'(u_if.pfdecode_valid), 64'd1);
        reset = 1'b1;
        exp_dec.delete(); exp_ret.delete(); exp_pred.delete();
        tick();
        check("rst2_dec_valid", 64'(u_if.pfdecode_valid), 64'd0);
        check("rst2_ret_valid", 64'(u_if.pfretire_valid), 64'd0);
        check("rst2_pred_valid", 64'(u_if.corepred_valid), 64'd0);
        check("rst2_dec_drop", 64'(dec_drop_cnt), 64'd0);
        check("rst2_ret_drop", 64'(ret_drop_cnt), 64'd0);
        reset = 1'b0;
        u_if.pfdecode_retry = 1'b0; u_if.pfretire_retry = 1'b0; u_if.corepred_retry = 1'b0;
        tick();
        check("post_rst_dec_valid", 64'(u_if.pfdecode_valid), 64'd0);
        check("post_rst_ret_valid", 64'(u_if.pfretire_valid), 64'd0);
        check("post_rst_pred_valid", 64'(u_if.corepred_valid), 64'd0);
        tick();
        drain(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
